// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and one-hot helpers for the segment scan decoder.
package seg_scan_pkg;

  localparam int SEG_NUM_DIGITS = 10;

  localparam logic [3:0] GLYPH_P   = 4'hA;
  localparam logic [3:0] GLYPH_C   = 4'hB;
  localparam logic [3:0] GLYPH_BAD = 4'hF;

  // Segment patterns as {a,b,c,d,e,f,g}; dp is not part of the glyph.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_P = 7'b1100111;
  localparam logic [6:0] SEG_C = 7'b1001110;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Helpers work on a 16-bit view: char_idx is 4 bits, so NUM_DIGITS <= 16.
  function automatic logic [4:0] sel_popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] sel_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_glyph.sv
// Combinational 7-segment pattern to glyph code decoder (dp excluded).
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code
);

  always_comb begin
    case (i_seg)
      SEG_0:   o_code = 4'h0;
      SEG_1:   o_code = 4'h1;
      SEG_2:   o_code = 4'h2;
      SEG_3:   o_code = 4'h3;
      SEG_4:   o_code = 4'h4;
      SEG_5:   o_code = 4'h5;
      SEG_6:   o_code = 4'h6;
      SEG_7:   o_code = 4'h7;
      SEG_8:   o_code = 4'h8;
      SEG_9:   o_code = 4'h9;
      SEG_P:   o_code = GLYPH_P;
      SEG_C:   o_code = GLYPH_C;
      default: o_code = GLYPH_BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers characters from a multiplexed 7-segment scan and streams them per frame.
// Optional macro GLYPH_CHECK_EN: drop frames containing an undecodable glyph.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] sel,
  input  logic [7:0]            segm,
  input  logic                  char_ready,
  output logic                  char_valid,
  output logic [3:0]            char_code,
  output logic [3:0]            char_idx,
  output logic                  frame_last,
  output logic                  sync_err,
  output logic [7:0]            frame_cnt
);

  localparam logic [3:0] LAST_POS = 4'(NUM_DIGITS - 1);

  state_t                r_state;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            r_segm;
  logic [3:0]            r_last;
  logic [3:0]            r_buf [NUM_DIGITS];
  logic                  r_char_valid;
  logic [3:0]            r_char_code;
  logic [3:0]            r_char_idx;
  logic                  r_frame_last;
  logic                  r_sync_err;
  logic [7:0]            r_frame_cnt;

  logic [15:0] w_sel_ext;
  logic        w_valid;
  logic [3:0]  w_pos;
  logic [3:0]  w_glyph;
  logic        w_store;
  logic        w_err;
  logic        w_finish;
  logic        w_frame_bad;
  logic [3:0]  w_first_code;
  logic        w_unused_dp;

  // dp carries no glyph information and is dropped at the input stage.
  assign w_unused_dp = segm[0];

  assign w_sel_ext = 16'(r_sel);
  assign w_valid   = (sel_popcount(w_sel_ext) == 5'd1);
  assign w_pos     = sel_index(w_sel_ext);

  seg_glyph_decode u_glyph (
    .i_seg  (r_segm),
    .o_code (w_glyph)
  );

  always_comb begin
    w_store = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_HUNT: w_store = w_valid && (w_pos == '0);
      ST_COLLECT: begin
        if (w_valid) begin
          if ((w_pos == r_last + 4'd1) || (w_pos == r_last)) begin
            w_store = 1'b1;
          end else begin
            w_err   = 1'b1;
            w_store = (w_pos == '0);
          end
        end
      end
      default: ;
    endcase
  end

  assign w_finish     = w_store && (w_pos == LAST_POS);
  assign w_first_code = (w_pos == '0) ? w_glyph : r_buf[0];

`ifdef GLYPH_CHECK_EN
  // The sample being stored this cycle is not in r_buf yet, so substitute it.
  always_comb begin
    w_frame_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (((4'(i) == w_pos) ? w_glyph : r_buf[4'(i)]) == GLYPH_BAD) w_frame_bad = 1'b1;
    end
  end
`else
  assign w_frame_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_sel        <= '0;
      r_segm       <= '0;
      r_last       <= '0;
      r_buf        <= '{default: '0};
      r_char_valid <= 1'b0;
      r_char_code  <= '0;
      r_char_idx   <= '0;
      r_frame_last <= 1'b0;
      r_sync_err   <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_sel      <= sel;
      r_segm     <= segm[7:1];
      r_sync_err <= w_err || (w_finish && w_frame_bad);
      if (w_store) begin
        r_buf[w_pos] <= w_glyph;
        r_last       <= w_pos;
      end
      case (r_state)
        ST_HUNT, ST_COLLECT: begin
          if (w_finish) begin
            if (w_frame_bad) begin
              r_state <= ST_HUNT;
            end else begin
              r_state      <= ST_EMIT;
              r_char_valid <= 1'b1;
              r_char_code  <= w_first_code;
              r_char_idx   <= '0;
              r_frame_last <= (LAST_POS == '0);
            end
          end else if (w_store) begin
            r_state <= ST_COLLECT;
          end else if (w_err) begin
            r_state <= ST_HUNT;
          end
        end
        ST_EMIT: begin
          if (r_char_valid && char_ready) begin
            if (r_char_idx == LAST_POS) begin
              r_char_valid <= 1'b0;
              r_frame_last <= 1'b0;
              r_frame_cnt  <= r_frame_cnt + 8'd1;
              r_state      <= ST_HUNT;
            end else begin
              r_char_idx   <= r_char_idx + 4'd1;
              r_char_code  <= r_buf[r_char_idx + 4'd1];
              r_frame_last <= ((r_char_idx + 4'd1) == LAST_POS);
            end
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign char_valid = r_char_valid;
  assign char_code  = r_char_code;
  assign char_idx   = r_char_idx;
  assign frame_last = r_frame_last;
  assign sync_err   = r_sync_err;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 10, number of scanned digit positions.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port sel, input, NUM_DIGITS, one-hot digit select from the scanning display driver.
REQ-005 SHALL have port segm, input, 8, segment pattern: bit7=a … bit1=g, bit0=dp.
REQ-006 SHALL have port char_ready, input, 1, downstream ready.
REQ-007 SHALL have port char_valid, output, 1, character stream valid.
REQ-008 SHALL have port char_code, output, 4, decoded glyph code.
REQ-009 SHALL have port char_idx, output, 4, digit position of char_code.
REQ-010 SHALL have port frame_last, output, 1, high with the last character of a frame.
REQ-011 SHALL have port sync_err, output, 1, one-cycle pulse on scan-order violation.
REQ-012 SHALL have port frame_cnt, output, 8, count of emitted frames.

Function
REQ-013 SHALL register sel and segm in one input stage before any decoding.
REQ-014 SHALL ignore segm[0] (dp) and decode segm[7:1]:
- 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
- 1100111->0xA ('P'), 1001110->0xB ('C')
- any other pattern->0xF.
REQ-015 SHALL treat a registered sel with zero or more than one bit set as an idle sample: not stored, no state change.
REQ-016 SHALL implement states HUNT, COLLECT and EMIT.
REQ-017 In HUNT, a valid sample at position 0 SHALL store the glyph in buffer[0] and enter COLLECT; all other positions are ignored.
REQ-018 In COLLECT, the expected position is last+1. On the expected position, the block SHALL store the glyph. A repeat of the same position SHALL overwrite that buffer entry. Any other position SHALL pulse sync_err and return to HUNT; if that position is 0, the block SHALL instead restart COLLECT with it.
REQ-019 Storing position NUM_DIGITS-1 SHALL enter EMIT. char_valid SHALL rise 2 cycles after that sample appeared on the ports.
REQ-020 In EMIT, the block SHALL present buffer entries in index order 0..NUM_DIGITS-1 on char_code/char_idx. It SHALL advance only on char_valid&&char_ready, and SHALL hold all outputs stable while char_valid&&!char_ready.
REQ-021 frame_last SHALL equal char_valid && (char_idx==NUM_DIGITS-1).
REQ-022 The final handshake SHALL increment frame_cnt (wrapping 255->0) and return the block to HUNT in the next cycle.
REQ-023 Scan samples arriving during EMIT SHALL be ignored and SHALL NOT raise sync_err.
REQ-024 The block SHALL accept back-to-back ready and emit one character per cycle.

Reset
REQ-025 While rst_n=0, outputs SHALL be: char_valid=0, char_code=0, char_idx=0, frame_last=0, sync_err=0, frame_cnt=0. The state SHALL be HUNT, and the input registers and buffer SHALL be 0.
REQ-026 Reset asserted mid-COLLECT or mid-EMIT SHALL discard the partial frame immediately. No character SHALL be emitted after rst_n rises until a fresh position-0 sample is seen.

Configuration
REQ-027 With GLYPH_CHECK_EN defined, a frame containing any 0xF glyph SHALL NOT be emitted. In that case sync_err SHALL pulse once, frame_cnt SHALL be unchanged, and the state SHALL return to HUNT.
REQ-028 Without GLYPH_CHECK_EN, frames SHALL be emitted unconditionally, including 0xF codes.

Structure
REQ-029 Package seg_scan_pkg SHALL hold NUM_DIGITS default, glyph code constants (GLYPH_P=0xA, GLYPH_C=0xB, GLYPH_BAD=0xF), segment pattern constants and the state enum.
REQ-030 Glyph decoding SHALL be a combinational sub-module seg_glyph_decode (segm[7:1] in, 4-bit code out).

Verification
REQ-031 Scan "P,0,5,0,C,0,2,0,0,0" (positions 0..9) with char_ready=1 -> codes A,0,5,0,B,0,2,0,0,0; idx 0..9; frame_last on idx 9; frame_cnt=1.
REQ-032 Same frame with char_ready toggling 1/0 each cycle -> identical sequence, outputs stable during stalls, 10 handshakes total.
REQ-033 Positions 0,1,2,5 -> sync_err pulse at position 5, no output; subsequent full frame emits normally.
REQ-034 sel=0 and sel=10'b0000000011 idle samples interleaved within a valid frame -> frame emitted unchanged, no sync_err.
REQ-035 Frame with segm=8'b00000001 at position 3 -> GLYPH_CHECK_EN: no output, sync_err, frame_cnt unchanged; otherwise idx 3 carries 0xF.
REQ-036 rst_n pulsed low after the 5th character of EMIT -> char_valid=0 immediately, frame_cnt=0, and the next output appears only after a new full scan.
